digital_clock: RTL and testbench
================================

DIGITAL_CLOCK -- requirements
Module: digital_clock

Interface
REQ-001 SHALL have parameter SEC_MAX, default 59, last seconds value before wrap.
REQ-002 SHALL have parameter MIN_MAX, default 59, last minutes value before wrap.
REQ-003 SHALL have parameter HOUR_MAX, default 23, last hours value before wrap (24-hour format).
REQ-004 SHALL have port Clk_1sec  input  1  sole clock, 1 Hz; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clock_enable  input  1  1 = run mode (time advances), 0 = set mode (time held, adjust inputs active).
REQ-007 SHALL have port min_inc  input  1  level button; each rising edge adds one minute in set mode.
REQ-008 SHALL have port min_dec  input  1  level button; each rising edge subtracts one minute in set mode.
REQ-009 SHALL have port hour_inc  input  1  level button; each rising edge adds one hour in set mode.
REQ-010 SHALL have port hour_dec  input  1  level button; each rising edge subtracts one hour in set mode.
REQ-011 SHALL have ports seconds, minutes, hours  output  6 each  registered binary time, unsigned.

Function
REQ-012 SHALL, in run mode, increment seconds by 1 every clock; SEC_MAX -> 0 with carry to minutes.
REQ-013 SHALL increment minutes on seconds carry; MIN_MAX -> 0 with carry to hours.
REQ-014 SHALL increment hours on minutes carry; HOUR_MAX -> 0, no further carry (23:59:59 -> 00:00:00).
REQ-015 SHALL, in run mode, ignore all four adjust inputs (edge detectors still track them).
REQ-016 SHALL, in set mode, hold seconds unchanged and not advance time.
REQ-017 SHALL detect a rising edge as input=1 this cycle and registered previous value=0; one action per edge, regardless of hold duration.
REQ-018 SHALL apply an adjustment in the same clock edge on which the rising edge is sampled (outputs change 1 cycle after button goes high).
REQ-019 SHALL wrap min_inc MIN_MAX -> 0 and min_dec 0 -> MIN_MAX without affecting hours.
REQ-020 SHALL wrap hour_inc HOUR_MAX -> 0 and hour_dec 0 -> HOUR_MAX without affecting minutes.
REQ-021 SHALL leave minutes unchanged when min_inc and min_dec edges occur in the same cycle; same rule for hours.
REQ-022 SHALL apply simultaneous minute and hour adjustments independently in the same cycle.
REQ-023 SHALL never present values above SEC_MAX/MIN_MAX/HOUR_MAX on the outputs.
REQ-024 SHALL, on clock_enable 0->1, resume counting from the held value on the next edge.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, set seconds, minutes, hours to 0 and clear all edge-detect registers to 0.
REQ-026 SHALL give reset priority over run counting and adjustments.
REQ-027 SHALL treat a button already high on the first cycle after reset as one rising edge.

Structure
REQ-028 SHALL place SEC_MAX/MIN_MAX/HOUR_MAX defaults and the 6-bit time-field width in a shared package, clock_pkg.
REQ-029 SHALL use one sub-module, rise_detect (1-bit register plus AND), instantiated four times.
REQ-030 SHALL implement counters as three registered fields in the top module; no latches, no derived clocks.

Verification
REQ-031 Reset high 1 cycle, then clock_enable=1 for 61 cycles -> 00:01:01.
REQ-032 Preload to 23:59:59 via set mode, clock_enable=1, one cycle -> 00:00:00.
REQ-033 Set mode at 10:59:30, one min_inc edge -> 10:00:30; one min_dec edge -> 10:59:30.
REQ-034 Set mode at 00:00:xx, hour_dec edge -> 23:00:xx; hour_inc edge -> 00:00:xx; min_inc held high 10 cycles -> exactly +1 minute.
REQ-035 Set mode: min_inc and min_dec rise same cycle -> minutes unchanged; clock_enable=1 with min_inc toggling -> minutes advance only via seconds carry.
REQ-036 Reset asserted mid-count at 12:34:56 -> 00:00:00 on that edge, counting resumes after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-field width, default wrap limits and
// wrap-around step helpers for digital_clock.
package clock_pkg;
  localparam int TW = 6;

  typedef logic [TW-1:0] tval_t;

  localparam int SEC_MAX_DEF  = 59;
  localparam int MIN_MAX_DEF  = 59;
  localparam int HOUR_MAX_DEF = 23;

  function automatic tval_t wrap_inc(
    input tval_t v,
    input tval_t lim
  );
    return (v == lim) ? '0 : v + tval_t'(1);
  endfunction

  function automatic tval_t wrap_dec(
    input tval_t v,
    input tval_t lim
  );
    return (v == '0) ? lim : v - tval_t'(1);
  endfunction
endpackage

// File: rtl/digital_clock_rise_detect.sv
// Rising-edge detector: one-cycle pulse when d is 1 and was 0 last edge.
// Ports: clk, reset (sync, active-high), d (level), rise (pulse).
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;
endmodule

// File: rtl/digital_clock.sv
// 24h digital clock, run mode counts seconds, set mode adjusts min/hour.
// Ports: Clk_1sec, reset, clock_enable, 4 adjust buttons, h/m/s outputs.
module digital_clock
  import clock_pkg::*;
#(
  parameter int SEC_MAX  = SEC_MAX_DEF,
  parameter int MIN_MAX  = MIN_MAX_DEF,
  parameter int HOUR_MAX = HOUR_MAX_DEF
) (
  input  logic          Clk_1sec,
  input  logic          reset,
  input  logic          clock_enable,
  input  logic          min_inc,
  input  logic          min_dec,
  input  logic          hour_inc,
  input  logic          hour_dec,
  output logic [TW-1:0] seconds,
  output logic [TW-1:0] minutes,
  output logic [TW-1:0] hours
);
  localparam tval_t SEC_LIM  = tval_t'(SEC_MAX);
  localparam tval_t MIN_LIM  = tval_t'(MIN_MAX);
  localparam tval_t HOUR_LIM = tval_t'(HOUR_MAX);

  logic min_up, min_dn, hour_up, hour_dn;

  // Detectors keep tracking in run mode so that
  // a button held across a mode switch is not
  // seen as a fresh press.
  rise_detect u_min_inc (
    .clk   (Clk_1sec),
    .reset (reset),
    .d     (min_inc),
    .rise  (min_up)
  );

  rise_detect u_min_dec (
    .clk   (Clk_1sec),
    .reset (reset),
    .d     (min_dec),
    .rise  (min_dn)
  );

  rise_detect u_hour_inc (
    .clk   (Clk_1sec),
    .reset (reset),
    .d     (hour_inc),
    .rise  (hour_up)
  );

  rise_detect u_hour_dec (
    .clk   (Clk_1sec),
    .reset (reset),
    .d     (hour_dec),
    .rise  (hour_dn)
  );

  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
    end else if (clock_enable) begin
      seconds <= wrap_inc(seconds, SEC_LIM);
      if (seconds == SEC_LIM) begin
        minutes <= wrap_inc(minutes, MIN_LIM);
        if (minutes == MIN_LIM)
          hours <= wrap_inc(hours, HOUR_LIM);
      end
    end else begin
      // Opposing edges in one cycle cancel out.
      unique case (1'b1)
        (min_up & ~min_dn):
          minutes <= wrap_inc(minutes, MIN_LIM);
        (min_dn & ~min_up):
          minutes <= wrap_dec(minutes, MIN_LIM);
        default: ;
      endcase
      unique case (1'b1)
        (hour_up & ~hour_dn):
          hours <= wrap_inc(hours, HOUR_LIM);
        (hour_dn & ~hour_up):
          hours <= wrap_dec(hours, HOUR_LIM);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_digital_clock.sv
// Self-checking bench for digital_clock: vector table,
// directed corner sequences and random run vs a time model.
module tb_digital_clock;
  localparam int NS = 60;
  localparam int NM = 60;
  localparam int NH = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       mi = 1'b0;
  logic       md = 1'b0;
  logic       hi = 1'b0;
  logic       hd = 1'b0;
  logic [5:0] seconds, minutes, hours;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int  mh = 0, mm = 0, ms = 0;
  bit  p_mi = 0, p_md = 0, p_hi = 0, p_hd = 0;

  digital_clock dut (
    .Clk_1sec     (clk),
    .reset        (reset),
    .clock_enable (en),
    .min_inc      (mi),
    .min_dec      (md),
    .hour_inc     (hi),
    .hour_dec     (hd),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, en, mi, md, hi, hd;
    int h, m, s;
  } vec_t;

  vec_t tbl[$];

  function automatic void model_edge();
    bit e_mi, e_md, e_hi, e_hd;
    int tot;
    e_mi = mi & ~p_mi;
    e_md = md & ~p_md;
    e_hi = hi & ~p_hi;
    e_hd = hd & ~p_hd;
    if (reset) begin
      mh = 0; mm = 0; ms = 0;
      p_mi = 0; p_md = 0; p_hi = 0; p_hd = 0;
      return;
    end
    p_mi = mi; p_md = md; p_hi = hi; p_hd = hd;
    if (en) begin
      tot = ((mh * NM + mm) * NS + ms + 1) % (NH * NM * NS);
      ms = tot % NS;
      mm = (tot / NS) % NM;
      mh = tot / (NS * NM);
    end else begin
      mm = (mm + NM + int'(e_mi) - int'(e_md)) % NM;
      mh = (mh + NH + int'(e_hi) - int'(e_hd)) % NH;
    end
  endfunction

  task automatic chk(input string name, input int h, input int m, input int s);
    n_checks++;
    if (int'(hours) != h || int'(minutes) != m || int'(seconds) != s) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d:%0d want %0d:%0d:%0d",
               name, hours, minutes, seconds, h, m, s);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", mh, mm, ms);
    n_checks++;
    if (seconds > 6'd59 || minutes > 6'd59 || hours > 6'd23) begin
      n_fail++;
      $display("FAIL range: got %0d:%0d:%0d", hours, minutes, seconds);
    end
  endtask

  task automatic idle(input bit e);
    reset = 0; en = e; mi = 0; md = 0; hi = 0; hd = 0;
  endtask

  task automatic do_reset();
    idle(0);
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic run(input int n);
    idle(1);
    repeat (n) step();
  endtask

  // 0:min_inc 1:min_dec 2:hour_inc 3:hour_dec
  task automatic press(input int which, input int times);
    repeat (times) begin
      idle(0);
      case (which)
        0: mi = 1;
        1: md = 1;
        2: hi = 1;
        default: hd = 1;
      endcase
      step();
      idle(0);
      step();
    end
  endtask

  initial begin
    tbl.push_back('{1,0,0,0,0,0,  0, 0, 0});
    tbl.push_back('{0,0,1,0,0,0,  0, 1, 0});
    tbl.push_back('{0,0,1,0,0,0,  0, 1, 0});
    tbl.push_back('{0,0,0,0,0,0,  0, 1, 0});
    tbl.push_back('{0,0,0,0,0,1, 23, 1, 0});
    tbl.push_back('{0,0,0,0,1,0,  0, 1, 0});
    tbl.push_back('{0,0,1,1,0,0,  0, 1, 0});
    tbl.push_back('{0,1,0,0,0,0,  0, 1, 1});
    tbl.push_back('{0,1,0,0,0,0,  0, 1, 2});
    tbl.push_back('{0,0,0,1,0,0,  0, 0, 2});
    tbl.push_back('{0,0,1,0,0,1, 23, 1, 2});
    tbl.push_back('{1,1,1,1,1,1,  0, 0, 0});
    tbl.push_back('{0,0,0,0,1,0,  1, 0, 0});
    tbl.push_back('{0,1,1,0,1,0,  1, 0, 1});

    #2;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; en = tbl[i].en;
      mi = tbl[i].mi; md = tbl[i].md;
      hi = tbl[i].hi; hd = tbl[i].hd;
      step();
      chk($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].s);
    end

    // count 61 seconds from reset
    do_reset();
    chk("reset", 0, 0, 0);
    run(61);
    chk("run61", 0, 1, 1);

    // full-day rollover
    do_reset();
    run(59);
    press(3, 1);
    press(1, 1);
    chk("preload", 23, 59, 59);
    run(1);
    chk("rollover", 0, 0, 0);

    // minute wrap in set mode leaves hours alone
    do_reset();
    run(30);
    press(2, 10);
    press(1, 1);
    chk("set1059", 10, 59, 30);
    press(0, 1);
    chk("min_wrap_up", 10, 0, 30);
    press(1, 1);
    chk("min_wrap_dn", 10, 59, 30);

    // hour wrap and held button
    do_reset();
    press(3, 1);
    chk("hour_wrap_dn", 23, 0, 0);
    press(2, 1);
    chk("hour_wrap_up", 0, 0, 0);
    idle(0);
    mi = 1;
    repeat (10) step();
    mi = 0;
    step();
    chk("held_min", 0, 1, 0);

    // run mode ignores toggling button
    do_reset();
    idle(1);
    for (int i = 0; i < 70; i++) begin
      mi = i[0];
      step();
    end
    chk("run_ignore", 0, 1, 10);

    // reset mid-count
    do_reset();
    run(56);
    press(2, 12);
    press(0, 34);
    chk("set123456", 12, 34, 56);
    idle(1);
    reset = 1;
    step();
    chk("mid_reset", 0, 0, 0);
    run(3);
    chk("resume", 0, 0, 3);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 3) != 0);
      mi = $urandom_range(0, 1);
      md = $urandom_range(0, 1);
      hi = $urandom_range(0, 1);
      hd = $urandom_range(0, 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
